// File: rtl/spi_miso_collector.sv
// spi_miso_collector: frames three MISO bytes into an LTC2494 word with decode, valid/ready, timeout and overrun.
module spi_miso_collector #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_FPGA_clk,
  input  logic        i_FPGA_rst,
  input  logic        i_frame_start,
  input  logic        i_MISOdv,
  input  logic [7:0]  i_MISO_byte,
  input  logic        i_ready,
  input  logic        i_clr_status,
  output logic        o_busy,
  output logic        o_DataValid,
  output logic [23:0] o_frame,
  output logic [17:0] o_code,
  output logic        o_eoc_err,
  output logic        o_dmy_err,
  output logic        o_timeout,
  output logic        o_overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [15:0] shift, shift_nxt;
  logic done, abort, load;
  logic [23:0] word;
  assign word = {shift, i_MISO_byte};
  assign load = done && (!o_DataValid || i_ready);
  assign o_busy = (state == COLLECT);
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    tmr_nxt = tmr;
    shift_nxt = shift;
    done = 1'b0;
    abort = 1'b0;
    if (state == IDLE) begin
      if (i_frame_start) begin
        state_nxt = COLLECT;
        cnt_nxt = 2'd0;
        tmr_nxt = '0;
      end
    end else if (i_frame_start) begin
      // restart; a byte arriving with the start is byte 0 of the new frame
      cnt_nxt = i_MISOdv ? 2'd1 : 2'd0;
      tmr_nxt = '0;
      shift_nxt = i_MISOdv ? {shift[7:0], i_MISO_byte} : shift;
    end else if (i_MISOdv) begin
      shift_nxt = {shift[7:0], i_MISO_byte};
      cnt_nxt = cnt + 2'd1;
      tmr_nxt = '0;
      if (cnt == 2'd2) begin
        done = 1'b1;
        state_nxt = IDLE;
        cnt_nxt = 2'd0;
      end
    end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
      abort = 1'b1;
      state_nxt = IDLE;
      cnt_nxt = 2'd0;
      tmr_nxt = '0;
      shift_nxt = '0;
    end else begin
      tmr_nxt = tmr + 1'b1;
    end
  end
  always_ff @(posedge i_FPGA_clk) begin
    if (i_FPGA_rst) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      shift <= '0;
      o_DataValid <= 1'b0;
      o_frame <= '0;
      o_code <= '0;
      o_eoc_err <= 1'b0;
      o_dmy_err <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      tmr <= tmr_nxt;
      shift <= shift_nxt;
      o_timeout <= abort;
      o_DataValid <= load | (o_DataValid & ~i_ready);
      o_overrun <= (done & ~load) | (o_overrun & ~i_clr_status);
      if (load) begin
        o_frame <= word;
        o_eoc_err <= word[23];
        o_dmy_err <= word[22];
        o_code <= {1'b0, word[21:5]} - 18'd65536;
      end
    end
  end
endmodule

// File: tb/tb_spi_miso_collector.sv
// tb_spi_miso_collector: directed scenario tasks with hand-computed expectations.
module tb_spi_miso_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic miso_dv = 1'b0;
  logic [7:0] miso_byte = 8'h00;
  logic ready = 1'b0;
  logic clr_status = 1'b0;
  logic busy, data_valid, eoc_err, dmy_err, timeout, overrun;
  logic [23:0] frame;
  logic [17:0] code;
  int checks = 0;
  int failures = 0;

  spi_miso_collector #(.TIMEOUT_CYCLES(16)) dut (
    .i_FPGA_clk(clk), .i_FPGA_rst(rst), .i_frame_start(frame_start),
    .i_MISOdv(miso_dv), .i_MISO_byte(miso_byte), .i_ready(ready),
    .i_clr_status(clr_status), .o_busy(busy), .o_DataValid(data_valid),
    .o_frame(frame), .o_code(code), .o_eoc_err(eoc_err), .o_dmy_err(dmy_err),
    .o_timeout(timeout), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    miso_dv = 1'b1;
    miso_byte = b;
    tick();
    miso_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] w);
    start();
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, data_valid, frame, code, eoc_err, dmy_err, timeout, overrun} !== 48'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b dv=%b frame=%h code=%h to=%b ovr=%b want all 0", busy, data_valid, frame, code, timeout, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ready = 1'b1;
    start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy); end
    send(8'h20);
    send(8'h00);
    send(8'h00);
    checks++;
    if (data_valid !== 1'b1 || frame !== 24'h200000) begin
      failures++;
      $display("FAIL basic_word got dv=%b frame=%h want dv=1 frame=200000", data_valid, frame);
    end
    checks++;
    if (code !== 18'h00000 || eoc_err !== 1'b0 || dmy_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_decode got code=%h eoc=%b dmy=%b busy=%b want 00000 0 0 0", code, eoc_err, dmy_err, busy);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_dv_clear got %b want 0", data_valid); end
  endtask

  task automatic test_decode();
    send_frame(24'h3FFFE0);
    checks++;
    if (data_valid !== 1'b1 || code !== 18'h0FFFF) begin
      failures++;
      $display("FAIL decode_max got dv=%b code=%h want 1 0ffff", data_valid, code);
    end
    tick();
    send_frame(24'h000000);
    checks++;
    if (code !== 18'h30000 || eoc_err !== 1'b0 || dmy_err !== 1'b0) begin
      failures++;
      $display("FAIL decode_min got code=%h eoc=%b dmy=%b want 30000 0 0", code, eoc_err, dmy_err);
    end
    tick();
    send_frame(24'hC00000);
    checks++;
    if (eoc_err !== 1'b1 || dmy_err !== 1'b1 || frame !== 24'hC00000) begin
      failures++;
      $display("FAIL decode_flags got eoc=%b dmy=%b frame=%h want 1 1 c00000", eoc_err, dmy_err, frame);
    end
    tick();
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(24'h123456);
    checks++;
    if (data_valid !== 1'b1 || code !== 18'h391A2) begin
      failures++;
      $display("FAIL ovr_first got dv=%b code=%h want 1 391a2", data_valid, code);
    end
    send_frame(24'hABCDEF);
    checks++;
    if (overrun !== 1'b1 || frame !== 24'h123456 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_held got ovr=%b frame=%h dv=%b want 1 123456 1", overrun, frame, data_valid);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (overrun !== 1'b0 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_clear got ovr=%b dv=%b want 0 1", overrun, data_valid);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL ovr_release got dv=%b want 0", data_valid); end
  endtask

  task automatic test_timeout();
    int n;
    logic saw_dv;
    saw_dv = 1'b0;
    n = 0;
    start();
    send(8'h11);
    send(8'h22);
    for (int i = 1; i <= 40; i++) begin
      tick();
      saw_dv |= data_valid;
      if (timeout) begin n = i; break; end
    end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL timeout_delay got %0d want 16", n); end
    checks++;
    if (saw_dv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state got dv_seen=%b busy=%b want 0 0", saw_dv, busy);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_pulse got %b want 0", timeout); end
    send_frame(24'h200000);
    checks++;
    if (data_valid !== 1'b1 || frame !== 24'h200000 || code !== 18'h00000) begin
      failures++;
      $display("FAIL timeout_recover got dv=%b frame=%h code=%h want 1 200000 00000", data_valid, frame, code);
    end
    tick();
  endtask

  task automatic test_stray_restart();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_ignored got dv=%b busy=%b want 0 0", data_valid, busy);
    end
    start();
    send(8'hAA);
    start();
    send(8'h12);
    send(8'h34);
    send(8'h56);
    checks++;
    if (data_valid !== 1'b1 || frame !== 24'h123456) begin
      failures++;
      $display("FAIL restart_frame got dv=%b frame=%h want 1 123456", data_valid, frame);
    end
    tick();
    start();
    send(8'h11);
    frame_start = 1'b1;
    miso_dv = 1'b1;
    miso_byte = 8'h80;
    tick();
    frame_start = 1'b0;
    miso_dv = 1'b0;
    send(8'h00);
    send(8'h00);
    checks++;
    if (frame !== 24'h800000 || eoc_err !== 1'b1 || dmy_err !== 1'b0 || code !== 18'h30000) begin
      failures++;
      $display("FAIL restart_with_byte got frame=%h eoc=%b dmy=%b code=%h want 800000 1 0 30000", frame, eoc_err, dmy_err, code);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    send_frame(24'h200000);
    start();
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, data_valid, frame, code, eoc_err, dmy_err, timeout, overrun} !== 48'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b dv=%b frame=%h code=%h to=%b ovr=%b want all 0", busy, data_valid, frame, code, timeout, overrun);
    end
    ready = 1'b1;
    send_frame(24'h3FFFE0);
    checks++;
    if (data_valid !== 1'b1 || frame !== 24'h3FFFE0 || code !== 18'h0FFFF) begin
      failures++;
      $display("FAIL reset_recover got dv=%b frame=%h code=%h want 1 3fffe0 0ffff", data_valid, frame, code);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_overrun();
    test_timeout();
    test_stray_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
